// File: rtl/gru_ctrl_pkg.sv
// Shared types and defaults for the GRU sequence controller.
package gru_ctrl_pkg;

    localparam int SEQ_LEN_DEF      = 32'd15;
    localparam int CELL_LATENCY_DEF = 32'd18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_X  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } gru_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 32'sd1) ? $clog2(value) : 32'sd1;
    endfunction

endpackage

// File: rtl/gru_seq_ctrl_lat.sv
// Loadable down-counter that tracks the remaining GRU cell latency.
module lat_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         enable_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear beats load, load beats decrement; saturates at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/gru_seq_ctrl.sv
// Sequences x_t acceptance, cell latency and hidden-state loads across one
// GRU sequence, then holds the final state until the dense stack takes it.
module gru_seq_ctrl
    import gru_ctrl_pkg::*;
#(
    parameter int SEQ_LEN      = SEQ_LEN_DEF,
    parameter int CELL_LATENCY = CELL_LATENCY_DEF,
    parameter int IDX_W        = clog2_min1(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             cell_start,
    output logic             h_sel_zero,
    output logic             h_load,
    output logic             final_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy
);

    localparam int               LAT_W    = clog2_min1(CELL_LATENCY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CELL_LATENCY - 1);

    gru_state_e       state_q;
    gru_state_e       state_d;
    logic [IDX_W-1:0] step_q;
    logic [IDX_W-1:0] step_d;
    logic             lat_load_s;
    logic             lat_clear_s;
    logic             lat_zero_s;

    // During reset the outputs already present the IDLE view.
    assign in_ready   = reset | (state_q == ST_IDLE) | (state_q == ST_WAIT_X);
    assign cell_start = in_valid & in_ready & (reset | ~flush);
    assign out_valid  = ~reset & (state_q == ST_OUTPUT);
    assign busy       = ~reset & (state_q != ST_IDLE);
    assign h_sel_zero = reset | (step_q == '0);
    assign step_idx   = step_q;

    // Next state, step index and one-cycle load strobes.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        lat_load_s  = 1'b0;
        lat_clear_s = 1'b0;
        h_load      = 1'b0;
        final_load  = 1'b0;
        if (flush) begin
            state_d     = ST_IDLE;
            step_d      = '0;
            lat_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT_X: begin
                    if (cell_start) begin
                        state_d    = ST_COMPUTE;
                        lat_load_s = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_COMPUTE: begin
                    if (!lat_zero_s) begin
                        state_d = ST_COMPUTE;
                    end else if (step_q == LAST_IDX) begin
                        final_load = ~reset;
                        step_d     = '0;
                        state_d    = ST_OUTPUT;
                    end else begin
                        h_load  = ~reset;
                        step_d  = step_q + IDX_W'(1);
                        state_d = ST_WAIT_X;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OUTPUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // State and step registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    lat_down_counter #(
        .W (LAT_W)
    ) u_lat (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (lat_clear_s),
        .load_i     (lat_load_s),
        .load_val_i (LAT_LOAD),
        .enable_i   (state_q == ST_COMPUTE),
        .zero_o     (lat_zero_s)
    );

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Bench for gru_seq_ctrl: default instance plus a SEQ_LEN=1/CELL_LATENCY=1
// instance on shared stimulus, checked each cycle against a timing model.
module tb_gru_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, flush, out_ready;
    logic [1:0] rdy, cs, hz, hl, fl, ov, bsy;
    logic [3:0] st0;
    logic [0:0] st1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int SL [2] = '{15, 1};
    int LT [2] = '{18, 1};

    // Model: step number, cycle on which the running cell finishes, result held.
    int m_step [2] = '{0, 0};
    int m_done [2] = '{-1, -1};
    bit m_out  [2] = '{1'b0, 1'b0};

    int cs0_n, hl0_n, fl0_n, ov0_n, rdy0_n, hl1_n;
    int ov0_first, cs1_first, fl1_first, ov1_first;
    int cs0_t[$];
    int hl0_t[$];

    gru_seq_ctrl u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .flush(flush), .cell_start(cs[0]), .h_sel_zero(hz[0]), .h_load(hl[0]),
        .final_load(fl[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .step_idx(st0), .busy(bsy[0])
    );

    gru_seq_ctrl #(.SEQ_LEN(1), .CELL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .flush(flush), .cell_start(cs[1]), .h_sel_zero(hz[1]), .h_load(hl[1]),
        .final_load(fl[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .step_idx(st1), .busy(bsy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        cs0_n = 0; hl0_n = 0; fl0_n = 0; ov0_n = 0; rdy0_n = 0; hl1_n = 0;
        ov0_first = -1; cs1_first = -1; fl1_first = -1; ov1_first = -1;
        cs0_t.delete();
        hl0_t.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Per-cycle comparison against the model, then model advance.
    always @(negedge clk) begin : compare
        bit   computing, finishing, idle_m;
        logic e_rdy, e_cs, e_hl, e_fl, e_ov, e_busy, e_hz;
        int   act_step;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                computing = (cyc <= m_done[k]);
                finishing = computing && (cyc == m_done[k]) && !reset && !flush;
                idle_m    = !computing && !m_out[k] && (m_step[k] == 0);
                e_rdy  = reset || (!computing && !m_out[k]);
                e_cs   = in_valid && e_rdy && (reset || !flush);
                e_hl   = finishing && (m_step[k] < SL[k] - 1);
                e_fl   = finishing && (m_step[k] == SL[k] - 1);
                e_ov   = !reset && m_out[k];
                e_busy = !reset && !idle_m;
                e_hz   = reset || (m_step[k] == 0);
                act_step = (k == 0) ? 32'(st0) : 32'(st1);
                chkb($sformatf("u%0d.in_ready", k),   rdy[k], e_rdy);
                chkb($sformatf("u%0d.cell_start", k), cs[k],  e_cs);
                chkb($sformatf("u%0d.h_load", k),     hl[k],  e_hl);
                chkb($sformatf("u%0d.final_load", k), fl[k],  e_fl);
                chkb($sformatf("u%0d.out_valid", k),  ov[k],  e_ov);
                chkb($sformatf("u%0d.busy", k),       bsy[k], e_busy);
                chkb($sformatf("u%0d.h_sel_zero", k), hz[k],  e_hz);
                chk($sformatf("u%0d.step_idx", k), act_step, m_step[k]);
                if (reset || flush) begin
                    m_step[k] = 0;
                    m_done[k] = -1;
                    m_out[k]  = 1'b0;
                end else begin
                    if (e_cs) m_done[k] = cyc + LT[k];
                    if (finishing) begin
                        if (m_step[k] == SL[k] - 1) begin
                            m_out[k]  = 1'b1;
                            m_step[k] = 0;
                        end else begin
                            m_step[k] = m_step[k] + 1;
                        end
                    end
                    if (e_ov && out_ready) m_out[k] = 1'b0;
                end
            end
            if (cs[0]) begin cs0_n++; cs0_t.push_back(cyc); end
            if (hl[0]) begin hl0_n++; hl0_t.push_back(cyc); end
            if (fl[0]) fl0_n++;
            if (ov[0]) begin ov0_n++; if (ov0_first < 0) ov0_first = cyc; end
            if (rdy[0]) rdy0_n++;
            if (hl[1]) hl1_n++;
            if (cs[1] && cs1_first < 0) cs1_first = cyc;
            if (fl[1] && fl1_first < 0) fl1_first = cyc;
            if (ov[1] && ov1_first < 0) ov1_first = cyc;
        end
        cyc++;
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        clear_stats();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(2);
        chkb("rst.in_ready", rdy[0], 1'b1);
        chkb("rst.busy", bsy[0], 1'b0);
        chkb("rst.out_valid", ov[0], 1'b0);
        chkb("rst.h_sel_zero", hz[0], 1'b1);
        in_valid = 1'b1;
        #1;
        chkb("rst.cell_start_follows_in_valid", cs[0], 1'b1);

        // Back-to-back sequence, out_ready high.
        reset = 1'b0;
        clear_stats();
        tick(286);
        in_valid = 1'b0;
        tick(3);
        chk("p1.cell_start_count", cs0_n, 15);
        for (int i = 1; i < cs0_t.size(); i++)
            chk("p1.cell_start_spacing", cs0_t[i] - cs0_t[i-1], 19);
        chk("p1.h_load_count", hl0_n, 14);
        chk("p1.final_load_count", fl0_n, 1);
        chk("p1.out_valid_cycles", ov0_n, 1);
        chk("p1.out_valid_offset", ov0_first - cs0_t[0], 285);
        chk("p1.len1_final_load_offset", fl1_first - cs1_first, 1);
        chk("p1.len1_out_valid_offset", ov1_first - cs1_first, 2);
        chk("p1.len1_h_load_count", hl1_n, 0);

        // Dense stack stalls for 40 cycles.
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(285);
        in_valid = 1'b0;
        clear_stats();
        tick(40);
        chk("p2.out_valid_held", ov0_n, 40);
        chk("p2.in_ready_cycles", rdy0_n, 0);
        out_ready = 1'b1;
        tick(1);
        chkb("p2.idle_busy", bsy[0], 1'b0);
        chkb("p2.idle_in_ready", rdy[0], 1'b1);

        // Five-cycle gaps between samples.
        clear_stats();
        for (int s = 0; s < 4; s++) begin
            in_valid = 1'b1;
            tick(1);
            in_valid = 1'b0;
            tick(23);
        end
        chk("p3.h_load_count", hl0_n, 4);
        for (int i = 1; i < hl0_t.size(); i++)
            chk("p3.h_load_spacing", hl0_t[i] - hl0_t[i-1], 24);
        chk("p3.step_idx_waiting", 32'(st0), 4);
        chkb("p3.waiting_in_ready", rdy[0], 1'b1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;

        // Flush at step 7 with three latency cycles left.
        in_valid = 1'b1;
        tick(148);
        chk("p4.step_before_flush", 32'(st0), 7);
        flush = 1'b1;
        in_valid = 1'b0;
        clear_stats();
        tick(1);
        flush = 1'b0;
        chkb("p4.busy_after_flush", bsy[0], 1'b0);
        chk("p4.step_after_flush", 32'(st0), 0);
        chkb("p4.h_sel_zero_after_flush", hz[0], 1'b1);
        tick(8);
        chk("p4.no_h_load_after_flush", hl0_n, 0);

        // Reset while holding the result, then mid-compute.
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(285);
        in_valid = 1'b0;
        chkb("p5.in_output", ov[0], 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chkb("p5.out_valid_after_reset", ov[0], 1'b0);
        chkb("p5.busy_after_reset", bsy[0], 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(9);
        chkb("p5.busy_mid_compute", bsy[0], 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chkb("p5.out_valid_after_reset2", ov[0], 1'b0);
        chkb("p5.busy_after_reset2", bsy[0], 1'b0);
        chk("p5.step_after_reset2", 32'(st0), 0);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
